// File: rtl/config_flit_assembler.sv
// -----------------------------------------------------------------------------
// config_flit_assembler
//
// Upstream feeder of the configurator. Collects 32-bit configuration words from
// the PCIe MMIO write path into CONFIG_WORDS-word config flits. Flits whose
// config_id (word 0) is not a known configurator target are dropped. Accepted
// flits are buffered in a FIFO_DEPTH-entry FIFO and presented on a valid/ready
// stream.
//
// Optional feature (macro CONFIG_ASSEMBLER_TIMEOUT_EN): a partial flit that sees
// TIMEOUT consecutive cycles without an accepted word is aborted.
//
// Ports:
//   clk               core clock
//   rst               asynchronous, active-low reset
//   in_word_data      configuration word; word i lands in bits [32*i+31:32*i]
//   in_word_first     marks word 0 (config_id) of a flit
//   in_word_valid     word valid
//   in_word_ready     word accepted when valid & ready
//   out_config_data   assembled flit (FIFO head, straight from storage)
//   out_config_valid  a flit is available
//   out_config_ready  downstream ready; flit pops on valid & ready
//   stat_drop_cnt     saturating count of flits dropped for unknown config_id
//   stat_abort_cnt    saturating count of aborted partial flits / stray words
//   o_dbg_state       assembly FSM state (0 = IDLE, 1 = ASSEMBLE)
//
// Handshakes: a transfer happens on a rising clk edge where valid & ready are
// both high. A producer holding valid keeps its data stable until the transfer;
// the flit output never drops valid without a pop.
// -----------------------------------------------------------------------------
module config_flit_assembler #(
  parameter int          CONFIG_WORDS         = 16,
  parameter int          FIFO_DEPTH           = 4,
  parameter int          CNT_W                = 16,
  parameter int          TIMEOUT              = 1024,
  parameter logic [31:0] FLOW_TABLE_CONFIG_ID = 32'h0000_0001,
  parameter logic [31:0] TIMESTAMP_CONFIG_ID  = 32'h0000_0002
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [31:0]                 in_word_data,
  input  logic                        in_word_first,
  input  logic                        in_word_valid,
  output logic                        in_word_ready,
  output logic [32*CONFIG_WORDS-1:0]  out_config_data,
  output logic                        out_config_valid,
  input  logic                        out_config_ready,
  output logic [CNT_W-1:0]            stat_drop_cnt,
  output logic [CNT_W-1:0]            stat_abort_cnt,
  output logic [1:0]                  o_dbg_state
);

  localparam int FLIT_W = 32 * CONFIG_WORDS;
  localparam int WCNT_W = $clog2(CONFIG_WORDS);
  localparam int AW     = $clog2(FIFO_DEPTH);

  localparam logic [WCNT_W-1:0] LAST_WORD  = WCNT_W'(CONFIG_WORDS - 1);
  localparam logic [AW:0]       FULL_COUNT = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ASSEMBLE = 2'd1
  } state_t;

  // Assembly side
  state_t            r_state;
  logic [WCNT_W-1:0] r_cnt;
  logic [FLIT_W-1:0] r_flit;
  logic [CNT_W-1:0]  r_drop_cnt;
  logic [CNT_W-1:0]  r_abort_cnt;

  // FIFO side
  logic [FLIT_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;

  logic              w_full;
  logic              w_accept;
  logic              w_last;
  logic              w_id_ok;
  logic              w_push;
  logic              w_pop;
  logic [FLIT_W-1:0] w_flit_full;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  assign w_full = (r_count == FULL_COUNT);

  // Only the word that would complete a flit can be stalled, and only while the
  // FIFO is full. A pop in the same cycle does not release it (no bypass).
  assign in_word_ready = !(w_full && (r_state == ST_ASSEMBLE) && (r_cnt == LAST_WORD));
  assign w_accept      = in_word_valid && in_word_ready;

  assign w_last  = (r_state == ST_ASSEMBLE) && !in_word_first && (r_cnt == LAST_WORD);
  assign w_id_ok = (r_flit[31:0] == FLOW_TABLE_CONFIG_ID) ||
                   (r_flit[31:0] == TIMESTAMP_CONFIG_ID);
  assign w_push  = w_accept && w_last && w_id_ok;
  assign w_pop   = out_config_valid && out_config_ready;

  // The last word is written into the FIFO on the same edge it is accepted, so
  // the pushed flit is the held partial flit with the incoming word merged on top.
  always_comb begin
    w_flit_full                 = r_flit;
    w_flit_full[FLIT_W-1 -: 32] = in_word_data;
  end

`ifdef CONFIG_ASSEMBLER_TIMEOUT_EN
  localparam int                IW            = $clog2(TIMEOUT) + 1;
  localparam logic [IW-1:0]     IDLE_LIMIT_M1 = IW'(TIMEOUT - 1);
  logic [IW-1:0]                r_idle_cnt;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT > 0);
`endif

  // Assembly FSM and statistics
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_flit      <= '0;
      r_drop_cnt  <= '0;
      r_abort_cnt <= '0;
`ifdef CONFIG_ASSEMBLER_TIMEOUT_EN
      r_idle_cnt  <= '0;
`endif
    end else begin
      if (w_accept) begin
`ifdef CONFIG_ASSEMBLER_TIMEOUT_EN
        r_idle_cnt <= '0;
`endif
        if (in_word_first) begin
          // A new first word always restarts assembly; any partial flit is lost.
          r_flit[31:0] <= in_word_data;
          r_cnt        <= WCNT_W'(1);
          r_state      <= ST_ASSEMBLE;
          if (r_state == ST_ASSEMBLE) begin
            r_abort_cnt <= sat_inc(r_abort_cnt);
          end
        end else if (r_state == ST_IDLE) begin
          // Stray continuation word with no flit in progress.
          r_abort_cnt <= sat_inc(r_abort_cnt);
        end else begin
          r_flit[32*r_cnt +: 32] <= in_word_data;
          if (w_last) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            if (!w_id_ok) begin
              r_drop_cnt <= sat_inc(r_drop_cnt);
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      end
`ifdef CONFIG_ASSEMBLER_TIMEOUT_EN
      else if (r_state == ST_ASSEMBLE) begin
        // Fires on the edge where the idle count reaches TIMEOUT.
        if (r_idle_cnt == IDLE_LIMIT_M1) begin
          r_state     <= ST_IDLE;
          r_cnt       <= '0;
          r_idle_cnt  <= '0;
          r_abort_cnt <= sat_inc(r_abort_cnt);
        end else begin
          r_idle_cnt <= r_idle_cnt + 1'b1;
        end
      end
`endif
    end
  end

  // Flit FIFO: pointers wrap naturally, count has one extra bit for "full".
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_flit_full;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  assign out_config_valid = (r_count != '0);
  assign out_config_data  = r_mem[r_rd_ptr];
  assign stat_drop_cnt    = r_drop_cnt;
  assign stat_abort_cnt   = r_abort_cnt;
  assign o_dbg_state      = r_state;

endmodule
